// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared definitions for the 30 s countdown control stage.
//   - state_t        : run/pause/done FSM encoding
//   - DEB_CYCLES_DEF : default debounce period in clk cycles (10 ms @ 100 MHz)
//   - DEB_W_DEF      : default debounce counter width (must hold DEB_CYCLES)
package countdown_pkg;

    localparam int DEB_CYCLES_DEF = 1_000_000;
    localparam int DEB_W_DEF      = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//   Conditions one raw push-button: 2-FF synchronizer, stability counter,
//   accepted level, and a single-cycle pulse on each accepted rising edge.
//   Press-to-pulse latency is 2 + DEB_CYCLES + 1 clk; releases and bounces
//   shorter than DEB_CYCLES never produce a pulse.
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   raw   in   asynchronous raw button, active-high
//   level out  debounced (accepted) button level
//   pulse out  1-cycle pulse, one cycle after level rises
module btn_debounce_pulse
    import countdown_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            // Edge detect on the accepted level, one cycle behind it.
            pulse   <= level & ~level_q;
            // Count consecutive cycles in which the synced input disagrees
            // with the accepted level; any agreement restarts the window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Control stage ahead of the two-digit 30 s countdown datapath. Debounces
//   START/PAUSE and CLEAR, runs the IDLE/RUN/PAUSE/DONE FSM, and issues the
//   qualified decrement and reload pulses for the digit downcounters.
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   tick        in   1-cycle count-rate enable (1 Hz)
//   btn_sp_raw  in   raw START/PAUSE button
//   btn_clr_raw in   raw CLEAR button
//   count_zero  in   both digit counters read 0
//   dec_en      out  1-cycle decrement request to the ones downcounter
//   load        out  1-cycle reload request (counters back to 30)
//   running     out  high in RUN
//   expired     out  high in DONE
//   blink       out  in DONE toggles on every tick, else 0
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_sp_raw,
    input  logic btn_clr_raw,
    input  logic count_zero,
    output logic dec_en,
    output logic load,
    output logic running,
    output logic expired,
    output logic blink
);

    // Only the edge pulses drive the FSM; the accepted levels stay available
    // on the debouncer for other consumers.
    logic sp_level_unused;
    logic clr_level_unused;
    logic sp_p;
    logic clr_p;

    btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_sp (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_sp_raw),
        .level (sp_level_unused),
        .pulse (sp_p)
    );

    btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clr_raw),
        .level (clr_level_unused),
        .pulse (clr_p)
    );

    state_t state;
    state_t state_nx;
    logic   dec_nx;
    logic   load_nx;
    logic   blink_nx;

    always_comb begin
        state_nx = state;
        dec_nx   = 1'b0;
        load_nx  = 1'b0;
        if (clr_p) begin
            // CLEAR wins over START/PAUSE and tick in the same cycle.
            state_nx = IDLE;
            load_nx  = 1'b1;
        end else begin
            case (state)
                IDLE:    if (sp_p) state_nx = count_zero ? DONE : RUN;
                RUN: begin
                    // A press on a tick cycle pauses and swallows that tick.
                    if (sp_p) begin
                        state_nx = PAUSE;
                    end else if (tick) begin
                        if (count_zero) state_nx = DONE;
                        else            dec_nx   = 1'b1;
                    end
                end
                PAUSE:   if (sp_p) state_nx = RUN;
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
        // blink only runs while staying in DONE; entering or leaving clears it.
        blink_nx = ((state == DONE) && (state_nx == DONE)) ? (blink ^ tick) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dec_en  <= 1'b0;
            load    <= 1'b0;
            running <= 1'b0;
            expired <= 1'b0;
            blink   <= 1'b0;
        end else begin
            state   <= state_nx;
            dec_en  <= dec_nx;
            load    <= load_nx;
            running <= (state_nx == RUN);
            expired <= (state_nx == DONE);
            blink   <= blink_nx;
        end
    end

endmodule
